// File: rtl/branch_fb_queue_pkg.sv
// Shared core definitions used by the branch feedback queue.
//   peval_width      : number of branch-resolve execution lanes
//   branch_fb_depth  : default number of feedback queue entries
//   branch_pred_fb_t : one resolved-branch feedback record
package core;

  localparam int peval_width     = 2;
  localparam int branch_fb_depth = 8;

  typedef struct packed {
    logic        valid;
    logic        branch_taken;
    logic [31:0] base_pc;
  } branch_pred_fb_t;

endpackage

// File: rtl/branch_fb_queue_compact.sv
// Combinational lane compactor.
// For each lane it gives the write offset from the queue tail, which is the
// number of valid lanes below it. It also gives the total number of valid lanes.
//   valid    : per-lane valid bits, lane 0 is oldest
//   offset   : per-lane slot offset from tail (meaningful only for valid lanes)
//   push_cnt : popcount(valid)
module branch_fb_compact
  import core::*;
#(
  parameter int lanes = core::peval_width,
  localparam int LW   = $clog2(lanes + 1)
) (
  input  logic [lanes-1:0] valid,
  output logic [LW-1:0]    offset [lanes],
  output logic [LW-1:0]    push_cnt
);

  logic [LW-1:0] acc;

  // Prefix sum: each lane's offset is the count of valid lanes before it.
  always_comb begin
    acc = '0;
    for (int i = 0; i < lanes; i++) begin
      offset[i] = acc;
      acc       = acc + LW'(valid[i]);
    end
    push_cnt = acc;
  end

endmodule

// File: rtl/branch_fb_queue.sv
// Branch feedback queue.
// It takes resolved-branch outcomes from the execution lanes and sends them to
// branch_pred one per cycle, keeping program order. Lane 0 is oldest within a
// cycle.
//
// Handshake: the lanes may present valid results only in a cycle where
// res_ready is high. All valid lanes are accepted together in that cycle.
// res_ready comes only from the registered count. A valid lane while
// res_ready is low is dropped and sets the sticky overflow_err flag.
// branch_pred consumes fb when fb.valid && pred_en.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : drop all queued and same-cycle incoming feedback
//   pred_en      : consume enable from branch_pred
//   res_in       : per-lane resolved branches
//   res_ready    : lanes may present valid results
//   fb           : head entry, with valid forced to (count != 0)
//   occupancy    : current entry count
//   overflow_err : sticky protocol-violation flag
module branch_fb_queue
  import core::*;
#(
  parameter int depth  = core::branch_fb_depth,
  localparam int PTR_W = $clog2(depth),
  localparam int CNT_W = $clog2(depth + 1),
  localparam int LW    = $clog2(core::peval_width + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            pred_en,
  input  branch_pred_fb_t res_in [core::peval_width],
  output logic            res_ready,
  output branch_pred_fb_t fb,
  output logic [CNT_W-1:0] occupancy,
  output logic            overflow_err
);

  branch_pred_fb_t          mem_q [depth];
  branch_pred_fb_t          mem_d [depth];
  logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d, free_slots;
  logic                     overflow_q, overflow_d;

  logic [core::peval_width-1:0] lane_valid;
  logic [LW-1:0]                lane_off [core::peval_width];
  logic [LW-1:0]                push_cnt;
  logic                         any_valid, push_en, pop;

  always_comb begin
    for (int i = 0; i < core::peval_width; i++) lane_valid[i] = res_in[i].valid;
  end

  branch_fb_compact #(.lanes(core::peval_width)) u_compact (
    .valid    (lane_valid),
    .offset   (lane_off),
    .push_cnt (push_cnt)
  );

  // Ready looks only at the registered count, so a pop in the same cycle
  // cannot raise it. This keeps res_ready free of any path from pred_en.
  assign free_slots = CNT_W'(depth) - count_q;
  assign res_ready  = free_slots >= CNT_W'(core::peval_width);

  assign any_valid = |lane_valid;
  assign push_en   = res_ready && !flush;
  assign pop       = (count_q != '0) && pred_en && !flush;

  always_comb begin
    fb           = mem_q[head_q];
    fb.valid     = (count_q != '0);
    occupancy    = count_q;
    overflow_err = overflow_q;
  end

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (any_valid && !res_ready);

    if (flush) begin
      // Storage is left as is. The zeroed count hides the stale entries.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) begin
        for (int i = 0; i < core::peval_width; i++) begin
          if (lane_valid[i]) begin
            mem_d[PTR_W'(tail_q + PTR_W'(lane_off[i]))] = res_in[i];
          end
        end
        tail_d = PTR_W'(tail_q + PTR_W'(push_cnt));
      end
      if (pop) head_d = head_q + PTR_W'(1);
      count_d = count_q + (push_en ? CNT_W'(push_cnt) : '0) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/branch_fb_queue.md
Name: branch_fb_queue

Overview:
- Collects resolved-branch outcomes from the core::peval_width execution lanes and serialises them into the single-entry feedback port of branch_pred (core::branch_pred_fb_t, one per cycle).
- Sits between the branch-resolve lanes, upstream, and branch_pred, downstream.
- Preserves program order: lane 0 is oldest within a cycle, and earlier cycles are older than later ones.
- Provides backpressure to the lanes and a flush used on pipeline redirect.

Parameters:
- depth, 8: number of queue entries. Must be a power of two and >= core::peval_width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  drop all queued and incoming feedback this cycle
- pred_en  in  1  branch_pred enable; an entry is consumed only when this is high
- res_in[core::peval_width]  in  core::branch_pred_fb_t  per-lane resolved branch (valid, branch_taken, base_pc)
- res_ready  out  1  the lanes may present valid results this cycle
- fb  out  core::branch_pred_fb_t  feedback to branch_pred
- occupancy  out  $clog2(depth+1)  current entry count
- overflow_err  out  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: head, tail and count = 0; every storage entry = '0; overflow_err = 0.
  - Resulting outputs: fb = '0 (fb.valid = 0), res_ready = 1, occupancy = 0.
- Storage and pointers:
  - Circular buffer of depth entries of core::branch_pred_fb_t.
  - head and tail are $clog2(depth) bits and wrap modulo depth.
  - count is $clog2(depth+1) bits.
- Output:
  - fb = mem[head] with fb.valid forced to (count != 0). Combinational from registered state only.
  - There is no bypass: minimum latency from res_in to fb is 1 cycle.
- Pop: occurs when fb.valid && pred_en. head advances by 1.
- Push:
  - Enabled when res_ready. Lanes with valid = 1 are compacted in ascending lane order.
  - Written at tail, tail+1, … (mod depth). tail advances by popcount(valid).
  - Lanes with valid = 0 leave gaps that are not stored.
- res_ready:
  - res_ready = (depth - count) >= core::peval_width, computed from registered count only.
  - A same-cycle pop does not raise it.
- Simultaneous push and pop:
  - count_next = count + pushed - popped.
  - Writing a slot at the same time the head entry is read is legal, because head != tail whenever a pop and a write target differ. The ready rule guarantees no entry is overwritten while unpopped.
- Protocol violation:
  - Any res_in valid while res_ready = 0: the inputs are ignored and overflow_err is set.
  - overflow_err is sticky and clears only on reset. flush does not clear it.
- flush:
  - Highest priority. Next cycle head = tail = count = 0.
  - Same-cycle pushes are discarded and no pop is counted. Storage is not cleared.
  - fb.valid = 0 the cycle after flush.
- Reset mid-operation: all state clears immediately (asynchronous). Queued outcomes are lost.
- occupancy = count.

Decomposition:
- Items for core package:
  - core::branch_pred_fb_t (existing).
  - core::peval_width (existing).
  - A new core::branch_fb_depth constant, used as the default for depth.
- Sub-module: branch_fb_compact. A combinational lane compactor producing per-lane write offsets and the push count (popcount). The queue instantiates it once.

Test Plan (core::peval_width = 2, depth = 8):
- Single push: lane0 {valid=1, taken=1, pc=0x40}, pred_en=1 → fb.valid=1 with pc=0x40, taken=1 on the next cycle. fb.valid=0 the cycle after. occupancy goes 0→1→0.
- Order and compaction:
  - Cycle A: lane0 pc=0x10, lane1 pc=0x14, both valid.
  - Cycle B: only lane1 pc=0x18 valid.
  - pred_en=1 throughout → fb pcs emitted as 0x10, 0x14, 0x18 on consecutive cycles.
- Backpressure: pred_en=0, push 2 per cycle → after 3 cycles occupancy=6 and res_ready=1; after the 4th push occupancy=8 and res_ready=0.
  - Raising pred_en drains 1 per cycle. res_ready returns to 1 once occupancy=6.
- Wrap: 10 single pushes interleaved with pops → head and tail wrap past 7. All 10 pcs emerge in order with no loss.
- Flush: occupancy=5 plus 2 valid lanes in the flush cycle → next cycle occupancy=0, fb.valid=0. The dropped pcs never appear.
- Violation and reset:
  - Valid lane while res_ready=0 → overflow_err=1; occupancy unchanged; the flag persists through flush.
  - Asserting rst_n=0 mid-cycle → fb.valid=0 and overflow_err=0 immediately.
